gshare_predictor: RTL

Parametrised gshare conditional-branch predictor for the instruction-fetch stage. It is the successor of the fixed 6-entry bimodal predictor. The table of 2-bit saturating counters has a configurable depth and is indexed by the fetch PC XORed with a speculative global history register (GHR). History is checkpointed at commit so a ROB rollback restores it exactly, and two saturating counters record branch and mispredict statistics. It sits between the PC manager (query side) and the ROB (commit/rollback side).

---
 rtl/gshare_predictor_if.sv | 30 +++
 rtl/gshare_predictor.sv | 110 +++++++++++
 2 files changed

// File: rtl/gshare_predictor_if.sv
// Query and commit/rollback bundle between fetch, the ROB and the gshare predictor.
interface gshare_predictor_if #(
  parameter int IDX_W = 6
);
  logic             query_valid;
  logic [31:0]      query_pc;
  logic             pred_taken;
  logic [IDX_W-1:0] pred_idx;
  logic             commit_valid;
  logic [IDX_W-1:0] commit_idx;
  logic             commit_taken;
  logic             commit_mispredict;
  logic             rollback;
  logic [31:0]      stat_branches;
  logic [31:0]      stat_mispredicts;

  // Pipeline side: issues queries and commits, observes predictions and statistics.
  modport master (
    output query_valid, query_pc, commit_valid, commit_idx, commit_taken,
           commit_mispredict, rollback,
    input  pred_taken, pred_idx, stat_branches, stat_mispredicts
  );

  // Predictor side.
  modport slave (
    input  query_valid, query_pc, commit_valid, commit_idx, commit_taken,
           commit_mispredict, rollback,
    output pred_taken, pred_idx, stat_branches, stat_mispredicts
  );
endinterface

// File: rtl/gshare_predictor.sv
// gshare conditional-branch predictor: 2-bit counter table indexed by PC xor
// speculative global history, with commit-time history checkpoint for rollback
// and saturating branch/mispredict statistics.
module gshare_predictor #(
  parameter int         IDX_W    = 6,
  parameter int         GHR_W    = 6,
  parameter logic [1:0] CNT_INIT = 2'b01
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  gshare_predictor_if.slave bus
);
  localparam int DEPTH = 2 ** IDX_W;

  logic [GHR_W-1:0] spec_ghr_reg, spec_ghr_next, spec_ghr_shift;
  logic [GHR_W-1:0] arch_ghr_reg, arch_ghr_next, arch_ghr_shift;
  logic [1:0]       cnt_reg [DEPTH];
  logic [1:0]       cnt_old, cnt_next;
  logic [IDX_W-1:0] ghr_ext;
  logic [31:0]      branches_reg, mispredicts_reg;
  logic             unused_pc;

  // Only the word-index bits of the PC take part in indexing.
  assign unused_pc = ^{bus.query_pc[31:IDX_W+2], bus.query_pc[1:0]};

  // History is zero-extended on the left when shorter than the index.
  assign ghr_ext        = IDX_W'(spec_ghr_reg);
  assign bus.pred_idx   = bus.query_pc[IDX_W+1:2] ^ ghr_ext;
  assign bus.pred_taken = cnt_reg[bus.pred_idx][1];

  // Shift the newest outcome into each history register.
  generate
    if (GHR_W == 1) begin : g_ghr_one
      assign spec_ghr_shift = bus.pred_taken;
      assign arch_ghr_shift = bus.commit_taken;
    end else begin : g_ghr_wide
      assign spec_ghr_shift = {spec_ghr_reg[GHR_W-2:0], bus.pred_taken};
      assign arch_ghr_shift = {arch_ghr_reg[GHR_W-2:0], bus.commit_taken};
    end
  endgenerate

  // Next history: rollback restores the checkpoint including this cycle's commit.
  always_comb begin
    arch_ghr_next = arch_ghr_reg;
    spec_ghr_next = spec_ghr_reg;
    if (bus.commit_valid) begin
      arch_ghr_next = arch_ghr_shift;
    end
    if (bus.rollback) begin
      spec_ghr_next = arch_ghr_next;
    end else if (bus.query_valid) begin
      spec_ghr_next = spec_ghr_shift;
    end
  end

  // History registers; rdy low freezes them.
  always_ff @(posedge clk) begin
    if (rst) begin
      spec_ghr_reg <= '0;
      arch_ghr_reg <= '0;
    end else if (rdy) begin
      spec_ghr_reg <= spec_ghr_next;
      arch_ghr_reg <= arch_ghr_next;
    end
  end

  // Saturating up/down step of the committed entry.
  always_comb begin
    cnt_old  = cnt_reg[bus.commit_idx];
    cnt_next = cnt_old;
    if (bus.commit_taken) begin
      if (cnt_old != 2'b11) cnt_next = cnt_old + 2'b01;
    end else begin
      if (cnt_old != 2'b00) cnt_next = cnt_old - 2'b01;
    end
  end

  // One register per table entry so reset can initialise the whole table.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cnt
      // Entry write: only the entry named by commit_idx changes.
      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_reg[gi] <= CNT_INIT;
        end else if (rdy && bus.commit_valid && (bus.commit_idx == IDX_W'(gi))) begin
          cnt_reg[gi] <= cnt_next;
        end
      end
    end
  endgenerate

  // Statistics counters, holding at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      branches_reg    <= '0;
      mispredicts_reg <= '0;
    end else if (rdy && bus.commit_valid) begin
      if (branches_reg != 32'hFFFF_FFFF) begin
        branches_reg <= branches_reg + 32'd1;
      end
      if (bus.commit_mispredict && (mispredicts_reg != 32'hFFFF_FFFF)) begin
        mispredicts_reg <= mispredicts_reg + 32'd1;
      end
    end
  end

  assign bus.stat_branches    = branches_reg;
  assign bus.stat_mispredicts = mispredicts_reg;
endmodule
